// File: rtl/lcd_stream_tx.sv
// lcd_stream_tx: PPU->LCD pixel stream transmitter.
// Generates DMG line/frame timing on lcd_mode and forwards 2-bit pixels from
// a valid/ready source to lcd_data with a one-clk lcd_clkena strobe.
// All timing advances on ce. The registered state describes the dot that the
// most recent ce started. Decisions taken at a ce use the dot being entered.
module lcd_stream_tx #(
    parameter int DOTS     = 456,
    parameter int LINES    = 154,
    parameter int VLINES   = 144,
    parameter int HPIX     = 160,
    parameter int OAM_DOTS = 80,
    parameter int M3_MAX   = 289
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       enable,
    input  logic [1:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [1:0] lcd_data,
    output logic       lcd_clkena,
    output logic [1:0] lcd_mode,
    output logic [7:0] line_cnt,
    output logic       frame_start,
    output logic       underrun,
    input  logic       underrun_clr
);

    localparam int DW = $clog2(OAM_DOTS + M3_MAX + 1) > $clog2(DOTS) ?
                        $clog2(OAM_DOTS + M3_MAX + 1) : $clog2(DOTS);
    localparam int PW = $clog2(HPIX + 1);

    localparam logic [DW-1:0] DOT_LAST  = DW'(DOTS - 1);
    localparam logic [DW-1:0] XFER_BEG  = DW'(OAM_DOTS);
    localparam logic [DW-1:0] XFER_END  = DW'(OAM_DOTS + M3_MAX);
    localparam logic [7:0]    LINE_LAST = 8'(LINES - 1);
    localparam logic [7:0]    VIS_LINES = 8'(VLINES);
    localparam logic [PW-1:0] PIX_LINE  = PW'(HPIX);

    typedef enum logic [1:0] {
        M_HBLANK = 2'b00,
        M_VBLANK = 2'b01,
        M_OAM    = 2'b10,
        M_XFER   = 2'b11
    } mode_e;

    logic          run_q;
    logic [DW-1:0] dot_q, dot_d;
    logic [7:0]    line_q, line_d;
    logic [PW-1:0] px_q;
    mode_e         mode_q, mode_d;
    logic [1:0]    data_q;
    logic          stb_q;
    logic          fs_q;
    logic          urun_q;

    logic          vis_d;
    logic          win;
    logic          hs;
    logic          abort;

    // Position and mode of the dot the next ce will enter.
    always_comb begin
        dot_d  = dot_q + 1'b1;
        line_d = line_q;
        if (dot_q == DOT_LAST) begin
            dot_d  = '0;
            line_d = (line_q == LINE_LAST) ? 8'd0 : line_q + 8'd1;
        end
        vis_d = (line_d < VIS_LINES);
        // Transfer window: still short of a full line and before the abort dot.
        win   = (dot_d >= XFER_BEG) && (dot_d < XFER_END) && (px_q < PIX_LINE);
        if (!vis_d)
            mode_d = M_VBLANK;
        else if (dot_d < XFER_BEG)
            mode_d = M_OAM;
        else if (win)
            mode_d = M_XFER;
        else
            mode_d = M_HBLANK;
    end

    // A pixel is taken on every ce that enters a transfer dot.
    assign pix_ready = ce & run_q & enable & vis_d & win;
    assign hs        = pix_valid & pix_ready;
    // Reaching the abort dot with the line still short flags an underrun.
    assign abort     = ce & run_q & enable & vis_d & (dot_d == XFER_END) & (px_q < PIX_LINE);

    // Line/frame timing FSM with registered mode, pixel and strobe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            dot_q  <= '0;
            line_q <= '0;
            px_q   <= '0;
            mode_q <= M_HBLANK;
            data_q <= 2'b00;
            stb_q  <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            fs_q  <= 1'b0;
            if (!enable) begin
                // LCD off: drop any partial line and hold idle.
                run_q  <= 1'b0;
                dot_q  <= '0;
                line_q <= '0;
                px_q   <= '0;
                mode_q <= M_HBLANK;
                data_q <= 2'b00;
            end else if (ce) begin
                if (!run_q) begin
                    // First ce after enable starts line 0 dot 0.
                    run_q  <= 1'b1;
                    dot_q  <= '0;
                    line_q <= '0;
                    px_q   <= '0;
                    mode_q <= M_OAM;
                    fs_q   <= 1'b1;
                end else begin
                    dot_q  <= dot_d;
                    line_q <= line_d;
                    mode_q <= mode_d;
                    if (dot_d == '0)
                        px_q <= '0;
                    else if (hs)
                        px_q <= px_q + 1'b1;
                    if (hs) begin
                        data_q <= pix_data;
                        stb_q  <= 1'b1;
                    end
                    if (dot_d == '0 && line_d == 8'd0)
                        fs_q <= 1'b1;
                end
            end
        end
    end

    // Sticky underrun flag; a new abort beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            urun_q <= 1'b0;
        else if (abort)
            urun_q <= 1'b1;
        else if (underrun_clr)
            urun_q <= 1'b0;
    end

    assign lcd_data    = data_q;
    assign lcd_clkena  = stb_q;
    assign lcd_mode    = mode_q;
    assign line_cnt    = line_q;
    assign frame_start = fs_q;
    assign underrun    = urun_q;

endmodule

// File: tb/tb_lcd_stream_tx.sv
// Bench for lcd_stream_tx: directed line patterns with hand-computed
// mode/strobe counts, plus a pixel scoreboard checked at every lcd_clkena.
module tb_lcd_stream_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pix_data = 2'b00;
    logic       pix_valid = 1'b0;
    logic       underrun_clr = 1'b0;
    logic       pix_ready;
    logic [1:0] lcd_data;
    logic       lcd_clkena;
    logic [1:0] lcd_mode;
    logic [7:0] line_cnt;
    logic       frame_start;
    logic       underrun;

    lcd_stream_tx dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .lcd_data(lcd_data), .lcd_clkena(lcd_clkena), .lcd_mode(lcd_mode),
        .line_cnt(line_cnt), .frame_start(frame_start), .underrun(underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs = 0;
    int mon_checks = 0;
    int mon_errs = 0;
    logic [1:0] exp_q[$];

    // per-run statistics
    int st_strobes, st_fs, st_fs_k0, st_rdy, st_first00;
    int st_mode_k0, st_line_k0, st_last_mode;
    int st_n[4];
    longint ce_total = 0;
    longint last_fs_ce = -1;
    longint fs_gap = -1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic pat(input int p, input int k);
        case (p)
            0: return 1'b1;              // always valid
            1: return (k % 2) == 0;      // toggles per ce, 1 on first xfer ce
            2: return k >= 100;          // stalled for the first 20 xfer ces
            default: return 1'b0;
        endcase
    endfunction

    // One clk: drive at negedge, record handshake, sample 1 unit after posedge.
    task automatic step(input logic c, input logic v, input logic clr, output logic rdy);
        @(negedge clk);
        ce = c;
        pix_valid = v;
        pix_data = 2'($urandom_range(3));
        underrun_clr = clr;
        #1;
        rdy = pix_ready;
        if (pix_valid && pix_ready) exp_q.push_back(pix_data);
        @(posedge clk);
        #1;
        if (lcd_clkena) st_strobes++;
        if (frame_start) begin
            st_fs++;
            if (c) begin
                if (last_fs_ce >= 0) fs_gap = ce_total - last_fs_ce;
                last_fs_ce = ce_total;
            end
        end
        if (c) ce_total++;
    endtask

    // n ces, one every 'period' clks; ce index k equals the dot it enters.
    task automatic run_ces(input int period, input int p, input int n, input int clr_at);
        logic r;
        st_strobes = 0; st_fs = 0; st_fs_k0 = 0; st_rdy = 0; st_first00 = -1;
        for (int m = 0; m < 4; m++) st_n[m] = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < period - 1; i++) begin
                step(1'b0, pat(p, k), 1'b0, r);
                if (r) st_rdy++;
            end
            step(1'b1, pat(p, k), (k == clr_at), r);
            if (r) st_rdy++;
            st_n[lcd_mode]++;
            if (lcd_mode == 2'b00 && st_first00 < 0) st_first00 = k;
            if (k == 0) begin
                st_mode_k0 = int'(lcd_mode);
                st_line_k0 = int'(line_cnt);
                st_fs_k0 = int'(frame_start);
            end
            st_last_mode = int'(lcd_mode);
        end
    endtask

    task automatic check_line(input string nm, input int strobes, input int n10,
                              input int n11, input int n00, input int first00, input int rdy);
        chk({nm, " strobes"}, st_strobes, strobes);
        chk({nm, " mode10 dots"}, st_n[2], n10);
        chk({nm, " mode11 dots"}, st_n[3], n11);
        chk({nm, " mode00 dots"}, st_n[0], n00);
        chk({nm, " first hblank dot"}, st_first00, first00);
        chk({nm, " ready ces"}, st_rdy, rdy);
    endtask

    // Scoreboard monitor: every strobe must match the oldest accepted pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (lcd_clkena) begin
                mon_checks++;
                if (exp_q.size() == 0) begin
                    mon_errs++;
                    $display("FAIL strobe: got unexpected lcd_data %0d required no strobe", lcd_data);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    if (lcd_data !== e) begin
                        mon_errs++;
                        $display("FAIL pixel: got %0d required %0d", lcd_data, e);
                    end
                end
                mon_checks++;
                if (lcd_mode !== 2'b11) begin
                    mon_errs++;
                    $display("FAIL strobe mode: got %0d required 3", lcd_mode);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic r;
        int prev_mode;

        // reset values, with ce/valid asserted to probe pix_ready
        ce = 1'b1; pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mode", lcd_mode, 0);
        chk("reset clkena", lcd_clkena, 0);
        chk("reset data", lcd_data, 0);
        chk("reset line", line_cnt, 0);
        chk("reset frame_start", frame_start, 0);
        chk("reset underrun", underrun, 0);
        chk("reset ready", pix_ready, 0);
        @(negedge clk);
        reset_n = 1'b1; ce = 1'b0; pix_valid = 1'b0;
        enable = 1'b1;
        step(1'b0, 1'b1, 1'b0, r);
        step(1'b0, 1'b1, 1'b0, r);
        chk("enabled no ce mode", lcd_mode, 0);
        chk("enabled no ce ready", r, 0);

        // line 0: always valid, ce every 4 clk
        run_ces(4, 0, 456, -1);
        check_line("t1", 160, 80, 160, 216, 240, 160);
        chk("t1 frame_start k0", st_fs_k0, 1);
        chk("t1 frame_start pulses", st_fs, 1);
        chk("t1 line", st_line_k0, 0);
        chk("t1 underrun", underrun, 0);

        // line 1: valid toggles per ce -> abort at dot 369
        run_ces(1, 1, 456, -1);
        check_line("t2", 145, 80, 289, 87, 369, 289);
        chk("t2 line", st_line_k0, 1);
        chk("t2 underrun", underrun, 1);

        // line 2: 20 stalled xfer ces then valid
        run_ces(1, 2, 456, -1);
        check_line("t3", 160, 80, 180, 196, 260, 180);
        chk("t3 underrun sticky", underrun, 1);

        for (int ln = 3; ln < 144; ln++) begin
            run_ces(1, 0, 456, -1);
            chk($sformatf("L%0d strobes", ln), st_strobes, 160);
            chk($sformatf("L%0d line", ln), st_line_k0, ln);
            chk($sformatf("L%0d frame_start", ln), st_fs, 0);
        end

        // vblank lines
        for (int ln = 144; ln < 154; ln++) begin
            run_ces(1, 0, 456, -1);
            chk($sformatf("V%0d mode01 dots", ln), st_n[1], 456);
            chk($sformatf("V%0d strobes", ln), st_strobes, 0);
            chk($sformatf("V%0d ready ces", ln), st_rdy, 0);
            chk($sformatf("V%0d line", ln), st_line_k0, ln);
        end
        prev_mode = st_last_mode;

        // next frame line 0: abort coincides with underrun_clr -> set wins
        run_ces(1, 1, 456, 369);
        chk("t4 mode before frame", prev_mode, 1);
        chk("t4 mode at line 0", st_mode_k0, 2);
        chk("t4 frame_start", st_fs_k0, 1);
        chk("t4 frame period ces", fs_gap, 70224);
        chk("t4 line", st_line_k0, 0);
        check_line("t6", 145, 80, 289, 87, 369, 289);
        chk("t6 underrun set wins", underrun, 1);
        step(1'b0, 1'b0, 1'b1, r);
        chk("underrun clear", underrun, 0);
        step(1'b0, 1'b0, 1'b0, r);
        chk("underrun stays clear", underrun, 0);

        // reset mid transfer
        run_ces(1, 0, 151, -1);
        chk("t5 mid xfer mode", lcd_mode, 3);
        @(negedge clk);
        #2;
        reset_n = 1'b0; enable = 1'b0; ce = 1'b1; pix_valid = 1'b1;
        #1;
        chk("t5 reset mode", lcd_mode, 0);
        chk("t5 reset data", lcd_data, 0);
        chk("t5 reset clkena", lcd_clkena, 0);
        chk("t5 reset line", line_cnt, 0);
        chk("t5 reset underrun", underrun, 0);
        chk("t5 reset ready", pix_ready, 0);
        chk("t5 queue drained", exp_q.size(), 0);
        @(negedge clk);
        reset_n = 1'b1; ce = 1'b0;
        last_fs_ce = -1;
        step(1'b0, 1'b0, 1'b0, r);
        chk("t5 idle after release", lcd_mode, 0);
        enable = 1'b1;
        run_ces(1, 0, 456, -1);
        chk("t5 restart frame_start", st_fs_k0, 1);
        chk("t5 restart mode", st_mode_k0, 2);
        chk("t5 restart line", st_line_k0, 0);
        chk("t5 restart strobes", st_strobes, 160);

        // enable dropped mid transfer
        run_ces(1, 0, 200, -1);
        @(negedge clk);
        enable = 1'b0; ce = 1'b0;
        @(posedge clk);
        #1;
        chk("disable mode", lcd_mode, 0);
        chk("disable line", line_cnt, 0);
        chk("disable clkena", lcd_clkena, 0);
        chk("disable underrun", underrun, 0);
        step(1'b1, 1'b1, 1'b0, r);
        chk("disable ready", r, 0);
        chk("disable stays idle", lcd_mode, 0);
        enable = 1'b1;
        run_ces(1, 0, 1, -1);
        chk("reenable frame_start", st_fs_k0, 1);
        chk("reenable mode", st_mode_k0, 2);
        chk("reenable line", st_line_k0, 0);

        step(1'b0, 1'b0, 1'b0, r);
        step(1'b0, 1'b0, 1'b0, r);
        chk("final queue empty", exp_q.size(), 0);

        n_checks += mon_checks;
        n_errs += mon_errs;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
